// File: rtl/pe_pkg.sv
// Shared PE definitions: operand mode encoding and lane width helpers
// reused by the multiplier pipeline and other PE blocks.
package pe_pkg;

    localparam logic MODE_INT16 = 1'b0;
    localparam logic MODE_INT8  = 1'b1;

    // Width of one packed sub-operand when a lane is split into two halves.
    function automatic int half_w(input int data_w);
        return data_w / 2;
    endfunction

    // Full-precision product width for a lane of data_w-bit operands.
    function automatic int prod_w(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/pe_mult_pipe_if.sv
// Operand/result handshake bundle between the neuron/weight buffers, the
// lane multiplier pipeline and the PE accumulation tree.
interface pe_mult_pipe_if
    import pe_pkg::*;
#(
    parameter int LANES  = 32,
    parameter int DATA_W = 16
);
    logic                                in_valid;
    logic                                in_ready;
    logic                                in_mode;
    logic                                in_signed;
    logic [LANES*DATA_W-1:0]             in_neuron;
    logic [LANES*DATA_W-1:0]             in_weight;
    logic                                out_valid;
    logic                                out_ready;
    logic [LANES*prod_w(DATA_W)-1:0]     out_result;
    logic                                out_mode;

    modport master (
        output in_valid, in_mode, in_signed, in_neuron, in_weight, out_ready,
        input  in_ready, out_valid, out_result, out_mode
    );

    modport slave (
        input  in_valid, in_mode, in_signed, in_neuron, in_weight, out_ready,
        output in_ready, out_valid, out_result, out_mode
    );

endinterface

// File: rtl/pe_mult_lane.sv
// One combinational PE lane: a full-width DATA_W multiply, or two packed
// DATA_W/2 multiplies, signed or unsigned.
module pe_mult_lane
    import pe_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0]         neuron,
    input  logic [DATA_W-1:0]         weight,
    input  logic                      mode,
    input  logic                      is_signed,
    output logic [prod_w(DATA_W)-1:0] result
);
    localparam int H  = half_w(DATA_W);
    localparam int PW = prod_w(DATA_W);

    logic [PW-1:0]     wide_n, wide_w, wide_p;
    logic [DATA_W-1:0] lo_n, lo_w, hi_n, hi_w, lo_p, hi_p;

    // Operands are extended to the product width (sign or zero per is_signed),
    // so a plain truncated multiply yields the exact product in both modes.
    // NOTE: combinational logic uses blocking assignments and assigns every
    // output on every path, so no latch can be inferred.
    always_comb begin
        wide_n = {{DATA_W{is_signed & neuron[DATA_W-1]}}, neuron};
        wide_w = {{DATA_W{is_signed & weight[DATA_W-1]}}, weight};
        wide_p = wide_n * wide_w;

        lo_n = {{H{is_signed & neuron[H-1]}}, neuron[H-1:0]};
        lo_w = {{H{is_signed & weight[H-1]}}, weight[H-1:0]};
        hi_n = {{H{is_signed & neuron[DATA_W-1]}}, neuron[DATA_W-1:H]};
        hi_w = {{H{is_signed & weight[DATA_W-1]}}, weight[DATA_W-1:H]};
        lo_p = lo_n * lo_w;
        hi_p = hi_n * hi_w;

        result = (mode == MODE_INT8) ? {hi_p, lo_p} : wide_p;
    end

endmodule

// File: rtl/pe_mult_pipe.sv
// Pipelined LANES-wide PE multiplier with bubble-collapsing valid/ready
// stages; per-beat mode travels alongside the products.
module pe_mult_pipe
    import pe_pkg::*;
#(
    parameter int LANES  = 32,
    parameter int DATA_W = 16,
    parameter int PIPE   = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    pe_mult_pipe_if.slave  bus
);
    localparam int PW = prod_w(DATA_W);
    localparam int RW = LANES * PW;

    logic [RW-1:0]            lane_result;
    logic [PIPE-1:0]          stage_valid;
    logic [PIPE-1:0]          stage_mode;
    logic [PIPE-1:0][RW-1:0]  stage_data;
    logic [PIPE-1:0]          stage_ready;
    logic [PIPE-1:0]          up_valid;
    logic [PIPE-1:0]          up_mode;
    logic [PIPE-1:0][RW-1:0]  up_data;
    logic                     ready_acc;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pe_mult_lane #(.DATA_W(DATA_W)) u_lane (
            .neuron    (bus.in_neuron[i*DATA_W +: DATA_W]),
            .weight    (bus.in_weight[i*DATA_W +: DATA_W]),
            .mode      (bus.in_mode),
            .is_signed (bus.in_signed),
            .result    (lane_result[i*PW +: PW])
        );
    end

    // A stage may load when it, or any stage downstream of it, is empty, or
    // when the consumer takes the output beat this cycle.
    always_comb begin
        stage_ready = '0;
        ready_acc   = bus.out_ready;
        for (int k = PIPE - 1; k >= 0; k--) begin
            ready_acc      = ready_acc | ~stage_valid[k];
            stage_ready[k] = ready_acc;
        end
    end

    always_comb begin
        up_valid    = stage_valid;
        up_mode     = stage_mode;
        up_data     = stage_data;
        up_valid[0] = bus.in_valid;
        up_mode[0]  = bus.in_mode;
        up_data[0]  = lane_result;
        for (int k = 1; k < PIPE; k++) begin
            up_valid[k] = stage_valid[k-1];
            up_mode[k]  = stage_mode[k-1];
            up_data[k]  = stage_data[k-1];
        end
    end

    // NOTE: stage payload registers are reset along with the valids because
    // the consumer observes out_result = 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= '0;
            stage_mode  <= '0;
            stage_data  <= '0;
        end else begin
            for (int k = 0; k < PIPE; k++) begin
                if (stage_ready[k]) begin
                    stage_valid[k] <= up_valid[k];
                    // Payload only moves with a real beat, so a held result
                    // is never disturbed by an incoming bubble.
                    if (up_valid[k]) begin
                        stage_mode[k] <= up_mode[k];
                        stage_data[k] <= up_data[k];
                    end
                end
            end
        end
    end

    assign bus.in_ready   = stage_ready[0];
    assign bus.out_valid  = stage_valid[PIPE-1];
    assign bus.out_mode   = stage_mode[PIPE-1];
    assign bus.out_result = stage_data[PIPE-1];

endmodule
